// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and helpers for the perceptron weight store.
//   - weight_t / sum_t    : signed weight and dot-product types (default config)
//   - W_MAX               : symmetric saturation bound for the default width
//   - sat_max()           : saturation bound for an arbitrary weight width
//   - pc_hash()           : PC -> row index fold
//   - train_decide()      : perceptron training rule (mispredict or low confidence)
package perceptron_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int N_WEIGHTS_DEF = 32;
  localparam int SUM_W_DEF     = WIDTH_DEF + $clog2(N_WEIGHTS_DEF);

  typedef logic signed [WIDTH_DEF-1:0] weight_t;
  typedef logic signed [SUM_W_DEF-1:0] sum_t;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Weights saturate symmetrically; the most negative code is never stored,
  // so negating a weight in the dot product cannot overflow.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  localparam int W_MAX = (1 << (WIDTH_DEF - 1)) - 1;

  // row = pc[idx_w+1:2] ^ pc[2*idx_w+1:idx_w+2]; result is zero above idx_w.
  function automatic logic [31:0] pc_hash(input logic [63:0] pc, input int idx_w);
    logic [31:0] h;
    h = '0;
    for (int i = 0; i < 32; i++)
      if (i < idx_w) h[i] = pc[i+2] ^ pc[i+2+idx_w];
    return h;
  endfunction

  // Train when the sign disagreed with the outcome or confidence was low.
  function automatic logic train_decide(input int sum, input logic taken, input int theta);
    int mag;
    mag = (sum < 0) ? -sum : sum;
    return ((sum >= 0) != taken) || (mag <= theta);
  endfunction

endpackage

// File: rtl/perceptron_row_update.sv
// perceptron_row_update: combinational saturating +/-1 update of one full row.
//   row     : current row, element 0 is the bias
//   hist    : history used at prediction (hist[i-1] pairs with weight i)
//   taken   : resolved outcome
//   row_new : updated row, clamped to [-sat_max(WIDTH), +sat_max(WIDTH)]
module perceptron_row_update
  import perceptron_pkg::*;
#(
  parameter int N_WEIGHTS = 32,
  parameter int WIDTH     = 8
) (
  input  logic [N_WEIGHTS-1:0][WIDTH-1:0] row,
  input  logic [N_WEIGHTS-2:0]            hist,
  input  logic                            taken,
  output logic [N_WEIGHTS-1:0][WIDTH-1:0] row_new
);

  localparam logic signed [WIDTH-1:0] WMAX = WIDTH'(sat_max(WIDTH));

  // Bias moves toward the outcome; weight i increments when its history bit
  // agreed with the outcome.
  logic [N_WEIGHTS-1:0] inc;
  assign inc = {~(hist ^ {(N_WEIGHTS-1){taken}}), taken};

  for (genvar i = 0; i < N_WEIGHTS; i++) begin : g_w
    logic signed [WIDTH-1:0] w;
    assign w = row[i];
    assign row_new[i] = inc[i] ? ((w <  WMAX) ? w + WIDTH'(1) : w)
                               : ((w > -WMAX) ? w - WIDTH'(1) : w);
  end

endmodule

// File: rtl/perceptron_weight_store.sv
// perceptron_weight_store: perceptron weight table with registered predict
// port and a two-stage in-place training pipeline.
//   clk, rst         : clock, asynchronous active-high reset
//   flush / ready    : full-table clear request / table usable
//   pred_*           : predict request (pc, history) -> registered sum, sign, row
//   train_*          : training request (row, history, sum, outcome); train_upd
//                      pulses in the cycle a row write is committed
// Build option: define PERCEPTRON_BYPASS_EN to let a predict read see the row
// update pending in the second training stage.
module perceptron_weight_store
  import perceptron_pkg::*;
#(
  parameter  int N_ROWS    = 64,
  parameter  int N_WEIGHTS = 32,
  parameter  int WIDTH     = 8,
  parameter  int PC_W      = 32,
  parameter  int THETA     = 75,
  localparam int IDX_W     = $clog2(N_ROWS),
  localparam int SUM_W     = WIDTH + $clog2(N_WEIGHTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    ready,
  input  logic                    pred_req,
  input  logic [PC_W-1:0]         pred_pc,
  input  logic [N_WEIGHTS-2:0]    pred_hist,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic signed [SUM_W-1:0] pred_sum,
  output logic [IDX_W-1:0]        pred_row,
  input  logic                    train_req,
  input  logic [IDX_W-1:0]        train_row,
  input  logic [N_WEIGHTS-2:0]    train_hist,
  input  logic signed [SUM_W-1:0] train_sum,
  input  logic                    train_taken,
  output logic                    train_upd
);

  typedef logic [N_WEIGHTS-1:0][WIDTH-1:0] row_t;

  row_t                   mem [N_ROWS];
  state_t                 state;
  logic [IDX_W-1:0]       clr_row;

  logic                   s1_pend;   // S1 holds a row write
  logic [IDX_W-1:0]       s1_row;
  row_t                   s1_data;
  logic [N_WEIGHTS-2:0]   s1_hist;
  logic                   s1_taken;
  row_t                   upd_row;

  logic                   accept;
  logic                   wr_en;
  logic [IDX_W-1:0]       pred_idx;
  row_t                   pred_rd;
  row_t                   trn_rd;
  logic                   trn_dec;
  logic signed [SUM_W-1:0] dot;
  logic signed [WIDTH-1:0] dw;

  assign ready  = (state == ST_RUN);
  // Flush wins over same-cycle requests and kills a pending S1 write.
  assign accept = (state == ST_RUN) && !flush;
  assign wr_en  = s1_pend && !flush;
  assign train_upd = wr_en;

  assign pred_idx = IDX_W'(pc_hash(64'(pred_pc), IDX_W));

  perceptron_row_update #(.N_WEIGHTS(N_WEIGHTS), .WIDTH(WIDTH)) u_upd (
    .row     (s1_data),
    .hist    (s1_hist),
    .taken   (s1_taken),
    .row_new (upd_row)
  );

  always_comb begin
    pred_rd = mem[pred_idx];
`ifdef PERCEPTRON_BYPASS_EN
    if (s1_pend && s1_row == pred_idx) pred_rd = upd_row;
`endif
  end

  // Train-to-train forwarding is unconditional so back-to-back trains accumulate.
  always_comb begin
    trn_rd = mem[train_row];
    if (s1_pend && s1_row == train_row) trn_rd = upd_row;
  end

  assign trn_dec = train_decide(int'(train_sum), train_taken, THETA);

  always_comb begin
    dw  = pred_rd[0];
    dot = SUM_W'(dw);
    for (int i = 1; i < N_WEIGHTS; i++) begin
      dw  = pred_rd[i];
      dot = pred_hist[i-1] ? dot + SUM_W'(dw) : dot - SUM_W'(dw);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_row    <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_sum   <= '0;
      pred_row   <= '0;
      s1_pend    <= 1'b0;
      s1_row     <= '0;
      s1_data    <= '0;
      s1_hist    <= '0;
      s1_taken   <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      s1_pend    <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_row <= clr_row + 1'b1;
          if (clr_row == IDX_W'(N_ROWS - 1)) state <= ST_RUN;
        end
        ST_RUN: if (flush) begin
          state   <= ST_CLEAR;
          clr_row <= '0;
        end
        default: state <= ST_CLEAR;
      endcase
      if (accept && pred_req) begin
        pred_valid <= 1'b1;
        pred_taken <= (dot >= 0);
        pred_sum   <= dot;
        pred_row   <= pred_idx;
      end
      if (accept && train_req) begin
        s1_pend  <= trn_dec;
        s1_row   <= train_row;
        s1_data  <= trn_rd;
        s1_hist  <= train_hist;
        s1_taken <= train_taken;
      end
    end
  end

  // Table storage: one zero row per cycle while clearing, else the S1 write.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_row] <= '0;
    else if (wr_en)        mem[s1_row]  <= upd_row;
  end

endmodule

// File: tb/tb_perceptron_weight_store.sv
module tb_perceptron_weight_store;
  localparam int N_ROWS = 64, N_WEIGHTS = 32, WIDTH = 8, PC_W = 32, THETA = 75;
  localparam int IDX_W = 6, SUM_W = 13;
`ifdef PERCEPTRON_BYPASS_EN
  localparam int BYP_EXP = 32;
`else
  localparam int BYP_EXP = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready;
  logic pred_req = 1'b0, pred_valid, pred_taken;
  logic [PC_W-1:0] pred_pc = '0;
  logic [N_WEIGHTS-2:0] pred_hist = '0, train_hist = '0;
  logic signed [SUM_W-1:0] pred_sum, train_sum = '0;
  logic [IDX_W-1:0] pred_row, train_row = '0;
  logic train_req = 1'b0, train_taken = 1'b0, train_upd;
  logic [N_WEIGHTS-2:0] ones, zeros;
  int checks = 0, errors = 0;
  int n;
  logic anyv;

  always #5 clk = ~clk;

  perceptron_weight_store #(
    .N_ROWS(N_ROWS), .N_WEIGHTS(N_WEIGHTS), .WIDTH(WIDTH), .PC_W(PC_W), .THETA(THETA)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_hist(pred_hist),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_sum(pred_sum), .pred_row(pred_row),
    .train_req(train_req), .train_row(train_row), .train_hist(train_hist),
    .train_sum(train_sum), .train_taken(train_taken), .train_upd(train_upd)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pred(input logic [PC_W-1:0] pc, input logic [N_WEIGHTS-2:0] h);
    pred_req = 1'b1; pred_pc = pc; pred_hist = h;
    tick();
    pred_req = 1'b0;
  endtask

  task automatic train(input logic [IDX_W-1:0] r, input logic [N_WEIGHTS-2:0] h,
                       input logic signed [SUM_W-1:0] s, input logic t);
    train_req = 1'b1; train_row = r; train_hist = h; train_sum = s; train_taken = t;
    tick();
    train_req = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin tick(); cnt++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ones = '1; zeros = '0;
    // reset values
    tick(); tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_sum", pred_sum, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_train_upd", train_upd, 0);
    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, 64);

    // zero table predicts taken with sum 0; hash check on 0x1234 -> 13^18 = 31
    pred(32'h1234, ones);
    chk("zero_valid", pred_valid, 1);
    chk("zero_sum", pred_sum, 0);
    chk("zero_taken", pred_taken, 1);
    chk("zero_row", pred_row, 31);
    tick();
    chk("valid_one_cycle", pred_valid, 0);

    // single train on row 5
    train(6'd5, ones, 13'sd0, 1'b1);
    chk("t5_upd", train_upd, 1);
    tick();
    chk("t5_upd_pulse", train_upd, 0);
    pred(32'd20, ones);
    chk("t5_sum", pred_sum, 32);
    chk("t5_row", pred_row, 5);

    // 199 more back-to-back trains: saturate at +127 each
    train_req = 1'b1; train_row = 6'd5; train_hist = ones; train_sum = 0; train_taken = 1'b1;
    repeat (199) tick();
    train_req = 1'b0;
    tick();
    pred(32'd20, ones);
    chk("sat_pos_sum", pred_sum, 4064);
    // hist zeros, taken 0: bias walks to -127, others stay at +127
    train_req = 1'b1; train_hist = zeros; train_taken = 1'b0;
    repeat (260) tick();
    train_req = 1'b0;
    tick();
    pred(32'd20, zeros);
    chk("sat_neg_sum", pred_sum, -4064);
    chk("sat_neg_taken", pred_taken, 0);
    pred(32'd20, ones);
    chk("sat_mix_sum", pred_sum, 3810);

    // back-to-back trains to row 9 accumulate through S1 forwarding
    train(6'd9, ones, 13'sd0, 1'b1);
    train(6'd9, ones, 13'sd0, 1'b1);
    chk("fwd_upd", train_upd, 1);
    tick();
    pred(32'd36, ones);
    chk("fwd_sum", pred_sum, 64);

    // threshold boundaries on row 12
    train(6'd12, ones, 13'sd100, 1'b1);
    chk("th100_upd", train_upd, 0);
    train(6'd12, ones, 13'sd76, 1'b1);
    chk("th76_upd", train_upd, 0);
    tick();
    pred(32'd48, ones);
    chk("th_unchanged", pred_sum, 0);
    train(6'd12, ones, 13'sd75, 1'b1);
    chk("th75_upd", train_upd, 1);
    tick();
    pred(32'd48, ones);
    chk("th75_sum", pred_sum, 32);
    train(6'd12, ones, -13'sd100, 1'b1);
    chk("mispred_upd", train_upd, 1);
    tick();
    pred(32'd48, ones);
    chk("mispred_sum", pred_sum, 64);

    // predict one cycle after a train to the same row
    train(6'd3, ones, 13'sd0, 1'b1);
    pred(32'd12, ones);
    chk("bypass_sum", pred_sum, BYP_EXP);
    pred(32'd12, ones);
    chk("after_write_sum", pred_sum, 32);

    // predict and train in the same cycle are both accepted
    pred_req = 1'b1; pred_pc = 32'd80; pred_hist = ones;
    train_req = 1'b1; train_row = 6'd20; train_hist = ones; train_sum = 0; train_taken = 1'b1;
    tick();
    pred_req = 1'b0; train_req = 1'b0;
    chk("dual_valid", pred_valid, 1);
    chk("dual_sum", pred_sum, 0);
    chk("dual_upd", train_upd, 1);
    tick();
    pred(32'd80, ones);
    chk("dual_after_sum", pred_sum, 32);

    // flush with a pending S1 write and a same-cycle predict
    train(6'd7, ones, 13'sd0, 1'b1);
    flush = 1'b1; pred_req = 1'b1; pred_pc = 32'd28; pred_hist = ones;
    #1;
    chk("flush_upd", train_upd, 0);
    tick();
    flush = 1'b0;
    chk("flush_pred_dropped", pred_valid, 0);
    chk("flush_ready", ready, 0);
    n = 0; anyv = 1'b0;
    while (!ready && n < 200) begin
      tick(); n++;
      if (pred_valid) anyv = 1'b1;
    end
    pred_req = 1'b0;
    chk("flush_clear_cycles", n, 64);
    chk("clear_ignores_req", anyv, 0);
    pred(32'd28, ones);
    chk("flush_row7", pred_sum, 0);
    pred(32'd20, ones);
    chk("flush_row5", pred_sum, 0);

    // asynchronous reset mid-operation
    pred(32'd20, ones);
    chk("pre_rst_valid", pred_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", pred_valid, 0);
    chk("async_rst_ready", ready, 0);
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("rst_clear_cycles", n, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/perceptron_weight_store.md
# perceptron_weight_store

Parametrised perceptron weight memory for the branch predictor. It hashes the PC into a row and returns a registered dot product of that row with global history. It trains rows in place with saturating ±1 updates, clears itself sequentially after reset or flush, and sits between the fetch-stage predictor and the branch-resolve stage.

## Interface
- N_ROWS, 64: perceptron rows; power of two; IDX_W = $clog2(N_ROWS)
- N_WEIGHTS, 32: weights per row; index 0 is bias, i ≥ 1 pairs with hist[i-1]
- WIDTH, 8: signed weight width
- PC_W, 32: PC width; must be ≥ 2*IDX_W+2
- THETA, 75: training threshold
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  request full table clear
- ready  out  1  table usable; low during clear
- pred_req  in  1  prediction request
- pred_pc  in  PC_W  branch PC
- pred_hist  in  N_WEIGHTS-1  global history, 1 = taken
- pred_valid  out  1  prediction result valid
- pred_taken  out  1  pred_sum ≥ 0
- pred_sum  out  SUM_W = WIDTH+$clog2(N_WEIGHTS), signed  perceptron output
- pred_row  out  IDX_W  row used; returned later on train_row
- train_req  in  1  resolved-branch training request
- train_row  in  IDX_W  row from prediction
- train_hist  in  N_WEIGHTS-1  history used at prediction
- train_sum  in  SUM_W  pred_sum from prediction
- train_taken  in  1  actual outcome
- train_upd  out  1  pulse: a row write occurred

## Operation
- Index: row = pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2].
- Predict: sum = w0 + Σ(hist[i-1] ? +w_i : −w_i); taken = sum ≥ 0.
- Train decision: update iff (train_sum ≥ 0) ≠ train_taken, or |train_sum| ≤ THETA.
- Update: t = train_taken ? +1 : −1; w0 += t; w_i += (train_hist[i-1] == train_taken) ? +1 : −1.
- Saturation is symmetric to [−(2^(WIDTH−1)−1), 2^(WIDTH−1)−1] (default ±127). −128 is never stored, so negation never overflows and SUM_W is exact.
- FSM states:
  - CLEAR: clr_row counts 0..N_ROWS−1 and writes one zero row per cycle; after row N_ROWS−1, go to RUN.
  - RUN: ready = 1; flush → CLEAR with clr_row = 0.
- Requests with ready = 0 are ignored. No pred_valid or train_upd is produced for them.
- Flush in RUN has priority over same-cycle requests, which are dropped. A training write pending at flush is discarded.
- Train pipeline accepts one request per cycle:
  - S0 (request cycle): read row, evaluate decision.
  - S1 (next cycle): compute saturated row, write at end of cycle, train_upd = 1 if the decision was true.
- Train hazard: a train to the row currently in S1 with a pending write reads the S1 updated data, not the array. Mandatory; back-to-back same-row trains accumulate.

## Timing
- Reset values: ready 0, pred_valid 0, pred_taken 0, pred_sum 0, pred_row 0, train_upd 0, S1 valid 0, state CLEAR, clr_row 0.
- Clear takes exactly N_ROWS cycles. ready rises in the cycle after the last row write.
- Reset asserted mid-operation aborts everything immediately, with outputs at reset values.
- Predict latency 1: pred_req at cycle T gives pred_valid/pred_taken/pred_sum/pred_row at T+1, held for one cycle only. Fully pipelined.
- Train write visible to predict reads from T+2. A predict at T+1 to the row in S1 follows Configuration.
- Predict and train in the same cycle are both accepted.

## Configuration
- PERCEPTRON_BYPASS_EN defined: a predict read of the row whose write is pending in S1 uses the updated S1 data.
- PERCEPTRON_BYPASS_EN undefined: that read returns the pre-update array contents.
- Train-to-train forwarding is unaffected by this macro.

## Structure
- Package perceptron_pkg holds:
  - weight/sum typedefs
  - the W_MAX saturation constant
  - the index hash function
  - the train-decision function
- Sub-module perceptron_row_update: combinational saturating update of one full row from (row, hist, taken). Used in S1.
- The FSM, clear counter, array, dot-product and forwarding muxes stay in the top.

## Test plan
- Reset, then idle: ready low for 64 cycles, high on cycle 65; pred_req with any PC → pred_sum 0, pred_taken 1.
- On zero table, train row 5, hist all ones, taken 1, train_sum 0: train_upd pulses 1 cycle later; predict row 5, hist all ones → pred_sum 32.
- 200 trains as above: pred_sum 4064 (32×127), never wraps; same row, hist all zeros, taken 0 trains saturate to −127.
- Two back-to-back trains to row 9 (taken, all-ones hist): pred_sum 64, proving S1 forwarding.
- train_sum 100, taken 1 (correct, above THETA): no train_upd, row unchanged. train_sum 75, taken 1: update occurs.
- Predict row 3 in the cycle after a train to row 3: pred_sum 32 with PERCEPTRON_BYPASS_EN, 0 without. Flush mid-train: write discarded, ready low 64 cycles, row reads 0.
